// File: rtl/wrr_burst_arbiter.sv
// wrr_burst_arbiter: 4-requester round-robin arbiter with per-requester burst
// quotas and a configurable turnaround gap between grants.
`default_nettype none

module wrr_burst_arbiter #(
    parameter int TURN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic        en,
    input  logic [11:0] cfg_quota,
    output logic [3:0]  gnt,
    output logic [1:0]  gnt_id,
    output logic        gnt_vld,
    output logic        preempt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam bit         HAS_GAP  = (TURN > 0);
    localparam logic [1:0] GAP_INIT = HAS_GAP ? 2'(TURN - 1) : 2'd0;

    state_t     state, state_nx;
    logic [3:0] gnt_nx;
    logic [1:0] gnt_id_nx;
    logic [1:0] last, last_nx;
    logic [2:0] cnt, cnt_nx;
    logic [2:0] quota, quota_nx;
    logic [1:0] gap_cnt, gap_cnt_nx;
    logic       preempt_nx;

    logic [1:0] win;
    logic [1:0] idx;
    logic       win_found;
    logic [2:0] win_quota;

    // Search last+1, last+2, last+3, last; the first set request wins.
    always_comb begin
        win       = last;
        win_found = 1'b0;
        idx       = last;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!win_found && req[idx]) begin
                win       = idx;
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        case (win)
            2'd0:    win_quota = cfg_quota[2:0];
            2'd1:    win_quota = cfg_quota[5:3];
            2'd2:    win_quota = cfg_quota[8:6];
            default: win_quota = cfg_quota[11:9];
        endcase
    end

    // cnt and quota are both kept in field encoding (cycles granted - 1),
    // so an 8-cycle burst never needs a fourth counter bit.
    always_comb begin
        state_nx   = state;
        gnt_nx     = gnt;
        gnt_id_nx  = gnt_id;
        last_nx    = last;
        cnt_nx     = cnt;
        quota_nx   = quota;
        gap_cnt_nx = gap_cnt;
        preempt_nx = 1'b0;
        case (state)
            IDLE: begin
                gnt_nx = 4'b0000;
                if (en && (req != 4'b0000)) begin
                    state_nx  = GRANT;
                    gnt_nx    = 4'b0001 << win;
                    gnt_id_nx = win;
                    last_nx   = win;
                    quota_nx  = win_quota;
                    cnt_nx    = 3'd0;
                end
            end
            GRANT: begin
                if (!req[gnt_id] || (cnt == quota)) begin
                    preempt_nx = req[gnt_id];
                    gnt_nx     = 4'b0000;
                    gap_cnt_nx = GAP_INIT;
                    state_nx   = HAS_GAP ? GAP : IDLE;
                end else begin
                    cnt_nx = cnt + 3'd1;
                end
            end
            GAP: begin
                gnt_nx = 4'b0000;
                if (gap_cnt == 2'd0) begin
                    state_nx = IDLE;
                end else begin
                    gap_cnt_nx = gap_cnt - 2'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= 4'b0000;
            gnt_id  <= 2'd0;
            gnt_vld <= 1'b0;
            preempt <= 1'b0;
            last    <= 2'd3;
            cnt     <= 3'd0;
            quota   <= 3'd0;
            gap_cnt <= 2'd0;
        end else begin
            state   <= state_nx;
            gnt     <= gnt_nx;
            gnt_id  <= gnt_id_nx;
            gnt_vld <= |gnt_nx;
            preempt <= preempt_nx;
            last    <= last_nx;
            cnt     <= cnt_nx;
            quota   <= quota_nx;
            gap_cnt <= gap_cnt_nx;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wrr_burst_arbiter.sv
// Directed bench for wrr_burst_arbiter: one instance with TURN=1 and one with
// TURN=0 share the same stimulus; each task checks the instance it targets.
`default_nettype none

module tb_wrr_burst_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic        en;
    logic [11:0] cfg_quota;

    logic [3:0]  gnt1, gnt0;
    logic [1:0]  id1, id0;
    logic        vld1, vld0;
    logic        pre1, pre0;

    int total = 0;
    int bad   = 0;

    wrr_burst_arbiter #(.TURN(1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req), .en(en), .cfg_quota(cfg_quota),
        .gnt(gnt1), .gnt_id(id1), .gnt_vld(vld1), .preempt(pre1)
    );

    wrr_burst_arbiter #(.TURN(0)) u_dut0 (
        .clk(clk), .rst(rst), .req(req), .en(en), .cfg_quota(cfg_quota),
        .gnt(gnt0), .gnt_id(id0), .gnt_vld(vld0), .preempt(pre0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled and inputs changed 1ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        req = 4'b0000;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; en = 1'b1; cfg_quota = 12'h000;
        #1;
        total++;
        if (gnt1 !== 4'b0000 || vld1 !== 1'b0 || pre1 !== 1'b0 || id1 !== 2'd0) begin
            bad++;
            $display("FAIL reset_async: gnt=%b vld=%b pre=%b id=%0d want 0000/0/0/0", gnt1, vld1, pre1, id1);
        end
        step(); step();
        total++;
        if (gnt1 !== 4'b0000 || vld1 !== 1'b0 || pre1 !== 1'b0 ||
            gnt0 !== 4'b0000 || vld0 !== 1'b0 || pre0 !== 1'b0) begin
            bad++;
            $display("FAIL reset_held: gnt1=%b vld1=%b pre1=%b gnt0=%b vld0=%b pre0=%b want zeros",
                     gnt1, vld1, pre1, gnt0, vld0, pre0);
        end
        req = 4'b0000;
        rst = 1'b0;
        step();
    endtask

    // TURN=0, Q=1 everywhere, all requesting: strict rotation from requester 0.
    task automatic test_rotation();
        logic [3:0] exp_g [9];
        logic [1:0] exp_id [9];
        exp_g  = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        exp_id = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        cfg_quota = 12'h000; en = 1'b1; req = 4'b1111;
        for (int i = 0; i < 9; i++) begin
            step();
            total++;
            if (gnt0 !== exp_g[i] || id0 !== exp_id[i] || pre0 !== 1'(i % 2) || vld0 !== (exp_g[i] != 4'b0000)) begin
                bad++;
                $display("FAIL rotation[%0d]: gnt=%b id=%0d pre=%b vld=%b want gnt=%b id=%0d pre=%0d",
                         i, gnt0, id0, pre0, vld0, exp_g[i], exp_id[i], i % 2);
            end
        end
        idle_cycles(4);
    endtask

    // TURN=1, Q0=4: four granted cycles, preempt pulse, two idle cycles, regrant.
    task automatic test_quota();
        logic [3:0] exp_g [8];
        logic       exp_p [8];
        exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        exp_p = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        cfg_quota = 12'h003; en = 1'b1; req = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) req = 4'b0000;
            step();
            if (i == 6) req = 4'b0000;
            total++;
            if (gnt1 !== exp_g[i] || pre1 !== exp_p[i] || id1 !== 2'd0) begin
                bad++;
                $display("FAIL quota[%0d]: gnt=%b pre=%b id=%0d want gnt=%b pre=%b id=0",
                         i, gnt1, pre1, id1, exp_g[i], exp_p[i]);
            end
        end
        idle_cycles(4);
    endtask

    // Q2=8 but the request drops after three granted cycles: release, no preempt.
    task automatic test_release();
        logic [3:0] exp_g [5];
        exp_g = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        cfg_quota = 12'h1C0; en = 1'b1; req = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 2) req = 4'b0000;
            total++;
            if (gnt1 !== exp_g[i] || pre1 !== 1'b0) begin
                bad++;
                $display("FAIL release[%0d]: gnt=%b pre=%b want gnt=%b pre=0", i, gnt1, pre1, exp_g[i]);
            end
        end
        idle_cycles(3);
    endtask

    // en gates grant start only; dropping en mid-grant keeps the full Q2=2 burst.
    task automatic test_enable();
        cfg_quota = 12'h040; en = 1'b0; req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (gnt1 !== 4'b0000) begin
                bad++;
                $display("FAIL enable_off[%0d]: gnt=%b want 0000", i, gnt1);
            end
        end
        en = 1'b1;
        step();
        total++;
        if (gnt1 !== 4'b0100 || id1 !== 2'd2 || vld1 !== 1'b1) begin
            bad++;
            $display("FAIL enable_on: gnt=%b id=%0d vld=%b want 0100/2/1", gnt1, id1, vld1);
        end
        en = 1'b0;
        step();
        total++;
        if (gnt1 !== 4'b0100 || pre1 !== 1'b0) begin
            bad++;
            $display("FAIL enable_mid: gnt=%b pre=%b want 0100/0", gnt1, pre1);
        end
        step();
        total++;
        if (gnt1 !== 4'b0000 || pre1 !== 1'b1) begin
            bad++;
            $display("FAIL enable_quota_end: gnt=%b pre=%b want 0000/1", gnt1, pre1);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (gnt1 !== 4'b0000 || pre1 !== 1'b0) begin
                bad++;
                $display("FAIL enable_hold_off[%0d]: gnt=%b pre=%b want 0000/0", i, gnt1, pre1);
            end
        end
        en = 1'b1;
        idle_cycles(3);
    endtask

    // Last grantee was 2; req=1011 with Q=1 and TURN=1 must serve 3, 0, 1.
    task automatic test_back_to_back();
        logic [3:0] exp_g [7];
        logic [1:0] exp_id [7];
        exp_g  = '{4'b1000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0010};
        exp_id = '{2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd1};
        cfg_quota = 12'h000; en = 1'b1; req = 4'b1011;
        for (int i = 0; i < 7; i++) begin
            step();
            total++;
            if (gnt1 !== exp_g[i] || id1 !== exp_id[i]) begin
                bad++;
                $display("FAIL back_to_back[%0d]: gnt=%b id=%0d want gnt=%b id=%0d",
                         i, gnt1, id1, exp_g[i], exp_id[i]);
            end
        end
        idle_cycles(3);
    endtask

    // Reset mid-burst clears outputs without a clock edge and without a preempt;
    // requester 0 then has top priority again.
    task automatic test_reset_mid_grant();
        cfg_quota = 12'h007; en = 1'b1; req = 4'b0001;
        step();
        step();
        total++;
        if (gnt1 !== 4'b0001) begin
            bad++;
            $display("FAIL mid_reset_pre: gnt=%b want 0001", gnt1);
        end
        rst = 1'b1;
        #1;
        total++;
        if (gnt1 !== 4'b0000 || vld1 !== 1'b0 || pre1 !== 1'b0 || id1 !== 2'd0) begin
            bad++;
            $display("FAIL mid_reset_async: gnt=%b vld=%b pre=%b id=%0d want 0000/0/0/0", gnt1, vld1, pre1, id1);
        end
        step();
        rst = 1'b0; req = 4'b1111; cfg_quota = 12'h000;
        step();
        total++;
        if (gnt1 !== 4'b0001 || id1 !== 2'd0 || pre1 !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_first: gnt=%b id=%0d pre=%b want 0001/0/0", gnt1, id1, pre1);
        end
        idle_cycles(3);
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000; en = 1'b0; cfg_quota = 12'h000;
        test_reset();
        test_rotation();
        test_quota();
        test_release();
        test_enable();
        test_back_to_back();
        test_reset_mid_grant();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
